// File: rtl/modulator_segmented_pkg.sv
`default_nettype none
// ============================================================================
// Module      : modulator_segmented_pkg
// Description : Shared constants, segment configuration type and helpers for
//               the two-segment modulator.
// Revision    : 1.0 - initial release
// ============================================================================
package modulator_segmented_pkg;

    localparam int          SEG_NUM      = 2;
    localparam logic [15:0] REP_INFINITE = 16'hFFFF;
    localparam int          PIPE_LATENCY = 4;

    // Per-segment playback configuration
    typedef struct packed {
        logic [15:0] cycle;     // last sample index of the segment
        logic [31:0] freq_div;  // clk ticks per sample
    } seg_cfg_t;

    // A divider of zero behaves as a divider of one
    function automatic logic [31:0] eff_div(input logic [31:0] freq_div);
        return (freq_div == 32'd0) ? 32'd1 : freq_div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/modulator_segmented_if.sv
`default_nettype none
// ============================================================================
// Module      : modulator_segmented_if
// Description : Control, buffer-write and streaming signals of the
//               two-segment modulator. master = driver, slave = modulator.
// Revision    : 1.0 - initial release
// ============================================================================
interface modulator_segmented_if
    import modulator_segmented_pkg::*;
#(
    parameter int WIDTH     = 13,
    parameter int MOD_WIDTH = 8,
    parameter int MOD_DEPTH = 32768
);
    localparam int AW = $clog2(MOD_DEPTH);

    logic                 sync;
    logic                 we;
    logic                 wr_seg;
    logic [AW-1:0]        wr_addr;
    logic [MOD_WIDTH-1:0] wr_data;
    logic [15:0]          cycle_0;
    logic [15:0]          cycle_1;
    logic [31:0]          freq_div_0;
    logic [31:0]          freq_div_1;
    logic                 req_valid;
    logic                 req_seg;
    logic [15:0]          req_rep;
    logic                 din_valid;
    logic [WIDTH-1:0]     duty_in;
    logic [WIDTH-1:0]     phase_in;
    logic [15:0]          delay_m;
    logic [WIDTH-1:0]     duty_out;
    logic [WIDTH-1:0]     phase_out;
    logic                 dout_valid;
    logic [15:0]          idx;
    logic                 cur_seg;
    logic                 stopped;

    modport master (
        output sync, we, wr_seg, wr_addr, wr_data, cycle_0, cycle_1,
               freq_div_0, freq_div_1, req_valid, req_seg, req_rep,
               din_valid, duty_in, phase_in, delay_m,
        input  duty_out, phase_out, dout_valid, idx, cur_seg, stopped
    );

    modport slave (
        input  sync, we, wr_seg, wr_addr, wr_data, cycle_0, cycle_1,
               freq_div_0, freq_div_1, req_valid, req_seg, req_rep,
               din_valid, duty_in, phase_in, delay_m,
        output duty_out, phase_out, dout_valid, idx, cur_seg, stopped
    );

endinterface
`default_nettype wire

// File: rtl/modulator_segmented_buffer.sv
`default_nettype none
// ============================================================================
// Module      : modulator_segmented_buffer
// Description : Simple dual-port sample RAM holding both segments,
//               addressed as {segment, sample}. Registered read (latency 1),
//               read-before-write on an address collision. Not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module modulator_segmented_buffer
    import modulator_segmented_pkg::*;
#(
    parameter int MOD_WIDTH = 8,
    parameter int MOD_DEPTH = 32768
) (
    input  logic                            clk,
    input  logic                            we,
    input  logic [$clog2(MOD_DEPTH):0]      wr_addr,
    input  logic [MOD_WIDTH-1:0]            wr_data,
    input  logic [$clog2(MOD_DEPTH):0]      rd_addr,
    output logic [MOD_WIDTH-1:0]            rd_data
);
    logic [MOD_WIDTH-1:0] r_mem [SEG_NUM*MOD_DEPTH];

    // Write port and registered read port; the read sees pre-write contents
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[wr_addr] <= wr_data;
        end
        rd_data <= r_mem[rd_addr];
    end

endmodule
`default_nettype wire

// File: rtl/modulator_segmented.sv
`default_nettype none
// ============================================================================
// Module      : modulator_segmented
// Description : Two-segment sample modulator. Plays one of two sample
//               buffers with per-segment length and rate, switches segment
//               on a cycle boundary with loop counting / stop, and scales
//               each streamed duty by the frame's sample in a 4-stage pipe.
//               Optional macro MODULATOR_DELAY_EN enables the per-transducer
//               sample delay (DELAY_M); otherwise the frame index is used.
// Revision    : 1.0 - initial release
// ============================================================================
module modulator_segmented
    import modulator_segmented_pkg::*;
#(
    parameter int WIDTH     = 13,
    parameter int DEPTH     = 249,
    parameter int MOD_WIDTH = 8,
    parameter int MOD_DEPTH = 32768
) (
    input  logic                clk,
    input  logic                rst,
    modulator_segmented_if.slave bus
);
    localparam int AW = $clog2(MOD_DEPTH);
    localparam int BW = $clog2(DEPTH + 1);
    localparam int PW = WIDTH + MOD_WIDTH + 1;

    // ------------------------------------------------------------------ sequencer
    seg_cfg_t    w_cfg [SEG_NUM];
    seg_cfg_t    w_act;
    logic [31:0] w_div_last;
    logic        w_tick, w_at_end, w_wrap, w_last_loop, w_apply;
    logic [15:0] r_idx, r_rep, r_loop;
    logic [31:0] r_div;
    logic        r_cur_seg, r_stopped;
    logic        r_pend_valid, r_pend_seg;
    logic [15:0] r_pend_rep;

    assign w_cfg[0]    = '{cycle: bus.cycle_0, freq_div: bus.freq_div_0};
    assign w_cfg[1]    = '{cycle: bus.cycle_1, freq_div: bus.freq_div_1};
    assign w_act       = w_cfg[r_cur_seg];
    assign w_div_last  = eff_div(w_act.freq_div) - 32'd1;
    assign w_tick      = (r_div >= w_div_last);
    // >= keeps IDX bounded if CYCLE is lowered while playing
    assign w_at_end    = (r_idx >= w_act.cycle);
    assign w_wrap      = w_tick && w_at_end && !r_stopped;
    assign w_last_loop = (r_rep != REP_INFINITE) && (r_loop == r_rep);
    // Only a request already registered can apply, so one arriving with a wrap waits
    assign w_apply     = r_pend_valid && (w_wrap || r_stopped);

    // Divider, sample index, loop count, stop and pending segment request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx        <= '0;
            r_div        <= '0;
            r_loop       <= '0;
            r_rep        <= REP_INFINITE;
            r_cur_seg    <= 1'b0;
            r_stopped    <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_seg   <= 1'b0;
            r_pend_rep   <= '0;
        end else begin
            if (bus.req_valid) begin
                r_pend_valid <= 1'b1;
                r_pend_seg   <= bus.req_seg;
                r_pend_rep   <= bus.req_rep;
            end else if (w_apply) begin
                r_pend_valid <= 1'b0;
            end

            if (w_apply) begin
                r_cur_seg <= r_pend_seg;
                r_rep     <= r_pend_rep;
                r_idx     <= '0;
                r_div     <= '0;
                r_loop    <= '0;
                r_stopped <= 1'b0;
            end else if (bus.sync) begin
                r_idx <= '0;
                r_div <= '0;
            end else if (!r_stopped) begin
                if (w_tick) begin
                    r_div <= '0;
                    if (w_at_end) begin
                        if (w_last_loop) begin
                            r_stopped <= 1'b1;          // IDX holds at CYCLE
                        end else begin
                            r_idx  <= '0;
                            r_loop <= r_loop + 16'd1;
                        end
                    end else begin
                        r_idx <= r_idx + 16'd1;
                    end
                end else begin
                    r_div <= r_div + 32'd1;
                end
            end
        end
    end

    assign bus.idx     = r_idx;
    assign bus.cur_seg = r_cur_seg;
    assign bus.stopped = r_stopped;

    // ---------------------------------------------------------- frame latching
    logic [BW-1:0] r_beat;
    logic [15:0]   r_f_idx, r_f_cycle, w_f_idx, w_f_cycle;
    logic          r_f_seg, w_f_seg, w_start;

    assign w_start   = bus.din_valid && (r_beat == '0);
    // The opening beat uses the live values, later beats the latched copy
    assign w_f_idx   = w_start ? r_idx        : r_f_idx;
    assign w_f_seg   = w_start ? r_cur_seg    : r_f_seg;
    assign w_f_cycle = w_start ? w_act.cycle  : r_f_cycle;

    // Beat counter and per-frame snapshot of index, segment and length
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat    <= '0;
            r_f_idx   <= '0;
            r_f_seg   <= 1'b0;
            r_f_cycle <= '0;
        end else if (bus.din_valid) begin
            r_beat <= (r_beat == BW'(DEPTH - 1)) ? '0 : r_beat + BW'(1);
            if (w_start) begin
                r_f_idx   <= r_idx;
                r_f_seg   <= r_cur_seg;
                r_f_cycle <= w_act.cycle;
            end
        end
    end

    // ------------------------------------------------------------ read address
    logic [16:0] w_addr_full;
    logic        w_unused_addr;
`ifdef MODULATOR_DELAY_EN
    logic [15:0] w_d;
    assign w_d = (bus.delay_m > w_f_cycle) ? w_f_cycle : bus.delay_m;
    assign w_addr_full = (w_f_idx >= w_d)
                       ? ({1'b0, w_f_idx} - {1'b0, w_d})
                       : ({1'b0, w_f_idx} + {1'b0, w_f_cycle} + 17'd1 - {1'b0, w_d});
`else
    logic w_unused_delay;
    assign w_addr_full    = {1'b0, w_f_idx};
    assign w_unused_delay = ^{bus.delay_m, w_f_cycle};
`endif
    assign w_unused_addr = ^w_addr_full[16:AW];

    // ---------------------------------------------------------------- pipeline
    logic                 r_s1_valid, r_s2_valid, r_s3_valid;
    logic                 r_s1_seg;
    logic [AW-1:0]        r_s1_addr;
    logic [WIDTH-1:0]     r_s1_duty, r_s1_phase, r_s2_duty, r_s2_phase;
    logic [WIDTH-1:0]     r_s3_duty, r_s3_phase;
    logic [MOD_WIDTH-1:0] w_sample;
    logic [MOD_WIDTH:0]   w_m1;
    logic [PW-1:0]        w_prod;
    logic                 w_unused_prod;

    modulator_segmented_buffer #(
        .MOD_WIDTH (MOD_WIDTH),
        .MOD_DEPTH (MOD_DEPTH)
    ) u_buffer (
        .clk     (clk),
        .we      (bus.we),
        .wr_addr ({bus.wr_seg, bus.wr_addr}),
        .wr_data (bus.wr_data),
        .rd_addr ({r_s1_seg, r_s1_addr}),
        .rd_data (w_sample)
    );

    assign w_m1          = {1'b0, w_sample} + {{MOD_WIDTH{1'b0}}, 1'b1};
    assign w_prod        = (w_sample == '0) ? '0
                         : ({{(MOD_WIDTH+1){1'b0}}, r_s2_duty} * {{WIDTH{1'b0}}, w_m1});
    assign w_unused_prod = ^{w_prod[MOD_WIDTH-1:0], w_prod[PW-1]};

    // Address -> RAM read -> multiply -> output register, flushed by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid     <= 1'b0;
            r_s2_valid     <= 1'b0;
            r_s3_valid     <= 1'b0;
            r_s1_seg       <= 1'b0;
            r_s1_addr      <= '0;
            r_s1_duty      <= '0;
            r_s1_phase     <= '0;
            r_s2_duty      <= '0;
            r_s2_phase     <= '0;
            r_s3_duty      <= '0;
            r_s3_phase     <= '0;
            bus.dout_valid <= 1'b0;
            bus.duty_out   <= '0;
            bus.phase_out  <= '0;
        end else begin
            r_s1_valid     <= bus.din_valid;
            r_s1_seg       <= w_f_seg;
            r_s1_addr      <= w_addr_full[AW-1:0];
            r_s1_duty      <= bus.duty_in;
            r_s1_phase     <= bus.phase_in;
            r_s2_valid     <= r_s1_valid;
            r_s2_duty      <= r_s1_duty;
            r_s2_phase     <= r_s1_phase;
            r_s3_valid     <= r_s2_valid;
            r_s3_duty      <= w_prod[MOD_WIDTH +: WIDTH];
            r_s3_phase     <= r_s2_phase;
            bus.dout_valid <= r_s3_valid;
            bus.duty_out   <= r_s3_duty;
            bus.phase_out  <= r_s3_phase;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_modulator_segmented.sv
`default_nettype none
// ============================================================================
// Module      : tb_modulator_segmented
// Description : Directed + randomized self-checking bench for
//               modulator_segmented with a sample-schedule reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_modulator_segmented;
    import modulator_segmented_pkg::*;

    localparam int WIDTH     = 13;
    localparam int DEPTH     = 249;
    localparam int MOD_WIDTH = 8;
    localparam int MOD_DEPTH = 32768;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    modulator_segmented_if #(.WIDTH(WIDTH), .MOD_WIDTH(MOD_WIDTH), .MOD_DEPTH(MOD_DEPTH)) bus ();

    modulator_segmented #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .MOD_WIDTH(MOD_WIDTH), .MOD_DEPTH(MOD_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int due;
        int duty;
        int phase;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t q[$];
    int   mem0[16];
    int   mem1[16];
    // Playback schedule: segment, reference edge (index 0, divider 0), rate, length
    int   m_seg, m_ref, m_div, m_cyc;
    int   beat_cnt, f_idx, f_seg, f_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int idx_model(input int n);
        return ((n - m_ref) / m_div) % (m_cyc + 1);
    endfunction

    function automatic int eff(input int f);
        return (f == 0) ? 1 : f;
    endfunction

    // One clock; then check the output stream against the scoreboard
    task automatic step();
        exp_t e;
        bit   ev;
        @(posedge clk);
        cyc++;
        #1;
        ev = (q.size() > 0) && (q[0].due == cyc);
        chk("dout_valid", {31'd0, bus.dout_valid}, {31'd0, ev});
        if (ev) begin
            e = q.pop_front();
            chk("duty_out", 32'(bus.duty_out), e.duty);
            chk("phase_out", 32'(bus.phase_out), e.phase);
        end
    endtask

    // Present one input beat (or idle) for a cycle and predict its output
    task automatic beat(input bit v, input int duty, input int phase, input int dly);
        int a, m, d;
        bus.din_valid = v;
        bus.duty_in   = WIDTH'(duty);
        bus.phase_in  = WIDTH'(phase);
        bus.delay_m   = 16'(dly);
        if (v) begin
            if (beat_cnt == 0) begin
                f_idx = idx_model(cyc);
                f_seg = m_seg;
                f_cyc = m_cyc;
            end
            beat_cnt = (beat_cnt + 1) % DEPTH;
`ifdef MODULATOR_DELAY_EN
            d = (dly > f_cyc) ? f_cyc : dly;
            a = (f_idx - d + f_cyc + 1) % (f_cyc + 1);
`else
            d = 0;
            a = f_idx + d;
`endif
            m = f_seg ? mem1[a] : mem0[a];
            q.push_back('{cyc + PIPE_LATENCY, (m == 0) ? 0 : ((duty * (m + 1)) >> MOD_WIDTH), phase});
        end
        step();
    endtask

    task automatic idle();
        beat(1'b0, 0, 0, 0);
    endtask

    task automatic rand_beat();
        beat(1'b1, $urandom_range(0, 8191), $urandom_range(0, 8191), $urandom_range(0, 9));
    endtask

    task automatic do_sync();
        bus.sync = 1'b1;
        idle();
        bus.sync = 1'b0;
        m_ref = cyc;
        m_seg = 0;
        m_div = eff(int'(bus.freq_div_0));
        m_cyc = int'(bus.cycle_0);
    endtask

    task automatic request(input bit seg, input int rep);
        bus.req_valid = 1'b1;
        bus.req_seg   = seg;
        bus.req_rep   = 16'(rep);
        idle();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        int s, w, k, n, a;
        bus.sync = 0; bus.we = 0; bus.wr_seg = 0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.cycle_0 = 16'd3; bus.cycle_1 = 16'd2; bus.freq_div_0 = 32'd2; bus.freq_div_1 = 32'd0;
        bus.req_valid = 0; bus.req_seg = 0; bus.req_rep = '0;
        bus.din_valid = 0; bus.duty_in = '0; bus.phase_in = '0; bus.delay_m = '0;
        beat_cnt = 0; m_seg = 0; m_ref = 0; m_div = 2; m_cyc = 3;

        // Reset state
        rst = 1'b1;
        repeat (3) idle();
        chk("rst_idx", 32'(bus.idx), 0);
        chk("rst_cur_seg", {31'd0, bus.cur_seg}, 0);
        chk("rst_stopped", {31'd0, bus.stopped}, 0);
        chk("rst_duty_out", 32'(bus.duty_out), 0);
        chk("rst_phase_out", 32'(bus.phase_out), 0);
        rst = 1'b0;

        // Load both segments
        mem0[0] = 255; mem0[1] = 128; mem0[2] = 0; mem0[3] = 64;
        for (int i = 4; i < 16; i++) mem0[i] = $urandom_range(0, 255);
        for (int i = 0; i < 16; i++) mem1[i] = $urandom_range(0, 255);
        mem1[1] = 0;
        for (int i = 0; i < 32; i++) begin
            bus.we      = 1'b1;
            bus.wr_seg  = (i >= 16);
            bus.wr_addr = 15'(i % 16);
            bus.wr_data = 8'((i >= 16) ? mem1[i % 16] : mem0[i % 16]);
            idle();
        end
        bus.we = 1'b0;

        // Four frames, one per sample, DUTY_IN=1000
        bus.cycle_0 = 16'd3; bus.freq_div_0 = 32'd249;
        do_sync();
        for (int f = 0; f < 4; f++)
            for (int b = 0; b < DEPTH; b++) beat(1'b1, 1000, $urandom_range(0, 8191), 0);
        repeat (5) idle();

        // IDX sequence at two clocks per sample
        bus.freq_div_0 = 32'd2;
        do_sync();
        for (int i = 0; i < 9; i++) begin
            chk("idx_seq", 32'(bus.idx), idx_model(cyc));
            idle();
        end

        // Single beat latency, then frames spanning index changes with gaps
        bus.freq_div_0 = 32'd100;
        do_sync();
        beat(1'b1, 4000, 'h123, 0);
        repeat (6) idle();
        for (int i = 0; i < 2 * DEPTH - 1; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            rand_beat();
        end
        repeat (5) idle();

        // Segment switch with overwrite, two loops of seg1 (divider 0), stop
        bus.freq_div_0 = 32'd2; bus.cycle_1 = 16'd2; bus.freq_div_1 = 32'd0;
        do_sync();
        s = m_ref;
        repeat (3) idle();
        request(1'b0, 5);
        request(1'b1, 1);
        w = s + 8;
        while (cyc <= s + 16) begin
            if (cyc < w) begin
                chk("sw_idx", 32'(bus.idx), idx_model(cyc));
                chk("sw_seg", {31'd0, bus.cur_seg}, 0);
                chk("sw_stop", {31'd0, bus.stopped}, 0);
            end else begin
                k = cyc - w;
                chk("sw_idx", 32'(bus.idx), (k < 6) ? (k % 3) : 2);
                chk("sw_seg", {31'd0, bus.cur_seg}, 1);
                chk("sw_stop", {31'd0, bus.stopped}, (k < 6) ? 0 : 1);
            end
            idle();
        end
        request(1'b0, 16'hFFFF);
        chk("stop_hold_seg", {31'd0, bus.cur_seg}, 1);
        idle();
        chk("stop_apply_seg", {31'd0, bus.cur_seg}, 0);
        chk("stop_apply_idx", 32'(bus.idx), 0);
        chk("stop_apply_stop", {31'd0, bus.stopped}, 0);
        a = cyc;

        // Request coinciding with a wrap waits for the following wrap
        while (cyc < a + 7) idle();
        request(1'b1, 16'hFFFF);
        chk("same_wrap_seg", {31'd0, bus.cur_seg}, 0);
        chk("same_wrap_idx", 32'(bus.idx), 0);
        while (cyc < a + 16) idle();
        chk("next_wrap_seg", {31'd0, bus.cur_seg}, 1);
        chk("next_wrap_idx", 32'(bus.idx), 0);
        m_seg = 1; m_ref = a + 16; m_div = 1; m_cyc = 2;

        // Partial frame in seg1, then reset mid-frame
        for (int i = 0; i < 20; i++) rand_beat();
        rst = 1'b1;
        q.delete();
        beat_cnt = 0;
        idle();
        n = cyc;
        chk("mid_rst_idx", 32'(bus.idx), 0);
        chk("mid_rst_seg", {31'd0, bus.cur_seg}, 0);
        chk("mid_rst_stop", {31'd0, bus.stopped}, 0);
        chk("mid_rst_duty", 32'(bus.duty_out), 0);
        chk("mid_rst_phase", 32'(bus.phase_out), 0);
        rst = 1'b0;
        m_seg = 0; m_ref = n; m_div = eff(int'(bus.freq_div_0)); m_cyc = int'(bus.cycle_0);
        repeat (2) idle();
        for (int i = 0; i < 12; i++) rand_beat();
        repeat (8) idle();
        chk("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/modulator_segmented.md
# modulator_segmented

Two-segment, parametrised successor to the current modulator. Holds two independent modulation sample buffers, each with its own cycle length and sample period, and switches between them only at a cycle boundary, with a programmable loop count and a stop state. It sits between the normal/STM duty-phase source and the PWM stage. Each streamed transducer duty is scaled by the current sample, and each transducer can read its sample with a delay offset.

## Interface
Parameters:
- WIDTH, 13, duty/phase width
- DEPTH, 249, transducers per frame (valid beats per frame)
- MOD_WIDTH, 8, sample width
- MOD_DEPTH, 32768, samples per segment

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- SYNC  in  1  pulse; clears divider and IDX to 0 (multi-device alignment)
- WE  in  1  buffer write strobe
- WR_SEG  in  1  target segment of the write
- WR_ADDR  in  $clog2(MOD_DEPTH)  write address
- WR_DATA  in  MOD_WIDTH  sample
- CYCLE_0, CYCLE_1  in  16 each  last sample index per segment
- FREQ_DIV_0, FREQ_DIV_1  in  32 each  CLK ticks per sample; 0 is treated as 1
- REQ_VALID  in  1  pulse; latches a segment-switch request
- REQ_SEG  in  1  requested segment
- REQ_REP  in  16  loops minus one; 16'hFFFF means infinite
- DIN_VALID  in  1  transducer beat valid
- DUTY_IN, PHASE_IN  in  WIDTH  per-transducer drive
- DELAY_M  in  16  per-transducer sample delay
- DUTY_OUT, PHASE_OUT  out  WIDTH  modulated drive
- DOUT_VALID  out  1
- IDX  out  16  current sample index
- CUR_SEG  out  1  active segment
- STOPPED  out  1  loop count exhausted

## Operation
- **Sample advance.** A divider counts 0 to FREQ_DIV_x−1 for the active segment. On terminal count, IDX increments. IDX wraps from CYCLE_x to 0.
- **Loop counting.** A loop counter tracks wraps.
- **Stop.** When the counter reaches REP+1 wraps and REP≠FFFF:
  - IDX freezes at CYCLE_x.
  - STOPPED goes to 1.
- **Segment switch request.**
  - A pending request register holds the latest REQ_VALID. A later request overwrites an unapplied one.
  - The request applies on the next wrap, or on the next cycle when STOPPED=1.
  - Applying it sets CUR_SEG, IDX=0, divider=0 and loop counter=0, clears STOPPED, and loads REP.
  - REQ_VALID arriving in the same cycle as a wrap is applied at the following wrap.
  - After reset the active segment is segment 0 with REP=FFFF.
- **Frame coherence.**
  - The first DIN_VALID after DEPTH beats (or after reset) starts a frame.
  - The frame latches IDX, CUR_SEG and CYCLE for all DEPTH beats.
  - IDX or segment changes during a frame affect only the next frame.
- **Read address.**
  - d = min(DELAY_M, CYCLE).
  - addr = idx−d if idx≥d, else idx+CYCLE+1−d.
- **Scaling.**
  - m=0 gives DUTY_OUT=0.
  - Otherwise DUTY_OUT = (DUTY_IN·(m+1))>>MOD_WIDTH, truncated.
  - PHASE_OUT = PHASE_IN, delayed to match.
- **Buffer writes.** Writes to the active segment are permitted and unprotected. A read in the same cycle as a write to the same address returns old data.
- **SYNC and reset outputs.**
  - SYNC has priority over the divider advance.
  - On reset every output is 0: IDX, CUR_SEG, STOPPED, DUTY_OUT, PHASE_OUT, DOUT_VALID. Buffer contents are not reset.

## Timing
- Pipeline latency is 4 CLK from DIN_VALID to DOUT_VALID:
  - stage 1: address
  - stage 2: BRAM read
  - stage 3: multiply
  - stage 4: output register
- Fully pipelined, one beat per cycle, no back-pressure.
- IDX, CUR_SEG and STOPPED are registered; they update 1 cycle after the causing event.
- RST mid-frame: in-flight beats are dropped, DOUT_VALID is low from the next cycle, and the frame counter restarts.

## Configuration
- MODULATOR_DELAY_EN defined: per-transducer delay applies as described in Operation.
- Not defined: DELAY_M is ignored, addr = latched idx, and the subtract/compare logic is removed. Latency stays 4.

## Structure
- Package modulator_segmented_pkg:
  - SEG_NUM=2
  - REP_INFINITE=16'hFFFF
  - PIPE_LATENCY=4
  - typedef for segment config (cycle, freq_div)
- Sub-module modulator_segmented_buffer: simple dual-port BRAM of 2·MOD_DEPTH×MOD_WIDTH.
  - Write side: {WR_SEG, WR_ADDR}.
  - Read side: {seg, addr}.
  - Read latency 1.

## Test plan
- Seg0 buffer [255,128,0,64], CYCLE_0=3, FREQ_DIV_0=2, DUTY_IN=1000 -> IDX sequence 0,0,1,1,2,2,3,3,0 and DUTY_OUT 1000, 503, 0, 253.
- Single beat at cycle t, PHASE_IN=0x123 -> DOUT_VALID only at t+4, PHASE_OUT=0x123.
- CYCLE=3, latched idx=1, DELAY_M=2 -> sample 3 used. DELAY_M=9 -> clamped to 3, sample 2 used. Without the macro -> sample 1 used.
- At IDX=2 in seg0, request seg1 with REP=1 -> CUR_SEG=1 after the wrap, seg1 plays two loops, then STOPPED=1 and IDX held at CYCLE_1. A new request to seg0 is applied on the next cycle.
- IDX advances mid-frame (DEPTH=249) -> all 249 beats use the latched idx; the next frame uses the new idx.
- RST during a frame -> next cycle all outputs 0, no DOUT_VALID for in-flight beats, CUR_SEG=0.
